// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Operands are widened by one bit so every signedness mix fits a signed multiply.
package mult_share_pkg;
  localparam int W   = 12;
  localparam int PW  = 24;
  localparam int LAT = 2;
  localparam int IDW = 2;

  typedef logic [IDW-1:0] id_t;
  typedef logic [W:0]     ext_t;

  typedef struct packed {
    logic valid;
    id_t  id;
    ext_t a_ext;
    ext_t b_ext;
  } stage_t;

  // Sign-extend when the operand is two's complement, zero-extend otherwise.
  function automatic ext_t extend(input logic [W-1:0] v, input logic sgn);
    return {sgn & v[W-1], v};
  endfunction
endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared multiplier.
interface mult_share_arbiter_if
  import mult_share_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_a_signed;
  logic [N_REQ-1:0]   req_b_signed;
  logic               rsp_valid;
  id_t                rsp_id;
  logic [PW-1:0]      rsp_p;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, req_a_signed, req_b_signed,
    output req_ready, rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_a_signed, req_b_signed,
    input  req_ready, rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mult_pipe2.sv
// Two-stage signed (W+1)x(W+1) multiplier; valid and id ride along with the data.
module mult_pipe2
  import mult_share_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  stage_t        in,
  output logic          out_valid,
  output id_t           out_id,
  output logic [PW-1:0] out_p,
  output logic          busy
);
  stage_t                s1;
  logic signed [2*W+1:0] prod;

  assign prod = $signed(s1.a_ext) * $signed(s1.b_ext);
  assign busy = s1.valid | out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_p     <= '0;
    end else begin
      s1        <= in;
      out_valid <= s1.valid;
      out_id    <= s1.id;
      // Low 2W bits are exact for every signedness mix.
      out_p     <= prod[PW-1:0];
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined 12x12 multiplier among up to four requesters,
// with per-operand signedness resolved by extension before the multiply.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic                  clk,
  input logic                  rst,
  mult_share_arbiter_if.slave  bus
);
  logic [N_REQ-1:0][W-1:0] a_lane, b_lane;
  ext_t [N_REQ-1:0]        a_ext, b_ext;
  logic [N_REQ-1:0]        grant;
  logic                    found;
  id_t                     gnt_id;
  id_t                     ptr;
  stage_t                  s_in;

  assign a_lane = bus.req_a;
  assign b_lane = bus.req_b;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign a_ext[i] = extend(a_lane[i], bus.req_a_signed[i]);
    assign b_ext[i] = extend(b_lane[i], bus.req_b_signed[i]);
  end

  // Search ptr, ptr+1, ... wrapping; first valid requester wins.
  always_comb begin
    int j;
    j      = 0;
    grant  = '0;
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && !rst && bus.req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gnt_id   = id_t'(j);
      end
    end
  end

  assign bus.req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + id_t'(1);
    end
  end

  always_comb begin
    s_in.valid = found;
    s_in.id    = gnt_id;
    s_in.a_ext = a_ext[gnt_id];
    s_in.b_ext = b_ext[gnt_id];
  end

  mult_pipe2 u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in        (s_in),
    .out_valid (bus.rsp_valid),
    .out_id    (bus.rsp_id),
    .out_p     (bus.rsp_p),
    .busy      (bus.busy)
  );
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a cycle-level reference model of round-robin grants
// and integer products, compared against the DUT every cycle, plus directed cases.
module tb_mult_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_arbiter_if #(.N_REQ(4)) bus ();
  mult_share_arbiter #(.N_REQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          due;
    int          id;
    logic [23:0] p;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          mptr  = 0;
  int          g;
  int          rsp_cnt = 0;
  int          snap;
  exp_t        q[$];
  exp_t        e;
  int          glog[$];
  logic [3:0]  last_ready = '0;
  logic [23:0] last_p;
  logic [1:0]  last_id;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Integer product of the two operands as their flags say they should be read.
  function automatic logic [23:0] model_prod(input logic [11:0] a, input bit as,
                                             input logic [11:0] b, input bit bs);
    longint av, bv, pr;
    av = longint'(a);
    bv = longint'(b);
    if (as && a[11]) av = av - 4096;
    if (bs && b[11]) bv = bv - 4096;
    pr = av * bv;
    return pr[23:0];
  endfunction

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_ready", {28'b0, bus.req_ready}, 32'h0);
      chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
      chk("rst_rsp_id", {30'b0, bus.rsp_id}, 32'h0);
      chk("rst_rsp_p", {8'b0, bus.rsp_p}, 32'h0);
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      q.delete();
      mptr = 0;
      last_ready = '0;
    end else begin
      g = pick(bus.req_valid, mptr);
      chk("ready", {28'b0, bus.req_ready}, (g >= 0) ? (32'h1 << g) : 32'h0);
      chk("busy", {31'b0, bus.busy}, {31'b0, q.size() != 0});
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("rsp_id", {30'b0, bus.rsp_id}, e.id);
        chk("rsp_p", {8'b0, bus.rsp_p}, {8'b0, e.p});
      end else begin
        chk("rsp_valid_idle", {31'b0, bus.rsp_valid}, 32'h0);
      end
      if (bus.rsp_valid) begin
        last_p  = bus.rsp_p;
        last_id = bus.rsp_id;
        rsp_cnt++;
      end
      if (g >= 0) begin
        q.push_back('{cyc + 2, g, model_prod(bus.req_a[g*12 +: 12], bus.req_a_signed[g],
                                             bus.req_b[g*12 +: 12], bus.req_b_signed[g])});
        glog.push_back(g);
        mptr = (g + 1) % 4;
      end
      last_ready = bus.req_ready;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic [11:0] a, input bit as,
                         input logic [11:0] b, input bit bs);
    bus.req_a[i*12 +: 12] = a;
    bus.req_b[i*12 +: 12] = b;
    bus.req_a_signed[i]   = as;
    bus.req_b_signed[i]   = bs;
  endtask

  // Single transfer from requester i, then drain; checks the product literally.
  task automatic one_op(input string nm, input int i, input logic [11:0] a, input bit as,
                        input logic [11:0] b, input bit bs, input logic [23:0] req_p);
    last_p  = '0;
    last_id = 2'h3;
    set_req(i, a, as, b, bs);
    bus.req_valid = 4'b0001 << i;
    step();
    bus.req_valid = '0;
    step(3);
    chk({nm, "_p"}, {8'b0, last_p}, {8'b0, req_p});
    chk({nm, "_id"}, {30'b0, last_id}, i);
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.req_a_signed = '0;
    bus.req_b_signed = '0;

    // Pin the model against hand-computed products.
    chk("model_mixed", {8'b0, model_prod(12'h0C8, 0, 12'hF38, 1)}, 32'hFF63C0);
    chk("model_uu", {8'b0, model_prod(12'h0C8, 0, 12'hF38, 0)}, 32'h0BE3C0);
    chk("model_ext", {8'b0, model_prod(12'h800, 1, 12'hFFF, 0)}, 32'h800800);

    // Round-robin with all four requesters valid straight out of reset.
    for (int i = 0; i < 4; i++) set_req(i, 12'(i * 37 + 5), i[0], 12'(i * 101 + 3), i[1]);
    bus.req_valid = 4'hF;
    step(2);
    glog.delete();
    rst = 1'b0;
    step(8);
    bus.req_valid = '0;
    step(3);
    chk("rr_count", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("rr_grant", glog[k], k % 4);

    one_op("mixed", 0, 12'h0C8, 0, 12'hF38, 1, 24'hFF63C0);
    one_op("uu", 1, 12'h0C8, 0, 12'hF38, 0, 24'h0BE3C0);
    one_op("ss", 2, 12'h0C8, 1, 12'hF38, 1, 24'hFF63C0);
    one_op("max_uu", 3, 12'hFFF, 0, 12'hFFF, 0, 24'hFFE001);
    one_op("min_ss", 0, 12'h800, 1, 12'h800, 1, 24'h400000);
    one_op("min_su", 1, 12'h800, 1, 12'hFFF, 0, 24'h800800);

    // Pointer rotation: after a grant to 2, requests from 1 and 3 go 3 then 1.
    glog.delete();
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b1010;
    step();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    step(3);
    chk("rot_count", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("rot_0", glog[0], 2);
      chk("rot_1", glog[1], 3);
      chk("rot_2", glog[2], 1);
    end

    // Reset one cycle after a grant: the in-flight product must vanish.
    set_req(2, 12'h123, 0, 12'h456, 0);
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    snap = rsp_cnt;
    step(4);
    chk("rst_drop", rsp_cnt - snap, 0);
    glog.delete();
    bus.req_valid = 4'b1001;
    step();
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = '0;
    step(3);
    chk("rst_ptr_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("rst_ptr_0", glog[0], 0);
      chk("rst_ptr_1", glog[1], 3);
    end

    // Random traffic; a requester holds its operands until granted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req_valid[i] || last_ready[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 99) < 60);
          set_req(i, 12'($urandom), 1'($urandom), 12'($urandom), 1'($urandom));
        end
      end
      step();
    end
    bus.req_valid = '0;
    step(4);
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
